loop_stack: RTL and testbench

- Hardware nested-loop stack for the control unit; successor to the single-level loop counter.
- Holds up to 2^LOOP_LOG_CNT nested loop contexts, each with its own iteration count and independence flag.
- For an independent innermost loop, issues up to 2^SUPERSCALAR_LOG_WIDTH iterations per step and clips the last batch to the remaining count.
- Adds overflow/underflow detection, replace-top (finish+create) and a stall enable.

---
 rtl/loop_stack_pkg.sv | 29 ++
 rtl/loop_stack_if.sv | 48 ++++
 rtl/loop_stack_batch_calc.sv | 39 +++
 rtl/loop_stack.sv | 171 +++++++++++++++++
 tb/tb_loop_stack.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/loop_stack_pkg.sv
// Shared types and constants for the nested-loop stack.
// Optional retired-iteration counter is enabled with LOOP_STACK_PERF_EN.
package loop_pkg;

    localparam int BITS                  = 15;
    localparam int LOOP_LOG_CNT          = 2;
    localparam int SUPERSCALAR_LOG_WIDTH = 2;

    localparam int LOOP_CNT = 1 << LOOP_LOG_CNT;
    localparam int SS_WIDTH = 1 << SUPERSCALAR_LOG_WIDTH;
    localparam int DEPTH_W  = LOOP_LOG_CNT + 1;
    localparam int REM_W    = BITS + 1;
    localparam int PERF_W   = 32;

    typedef struct packed {
        logic [BITS-1:0] count;
        logic [BITS-1:0] iter;
        logic            indep;
    } loop_entry_t;

    typedef enum logic [2:0] {
        CMD_NONE    = 3'd0,
        CMD_REPLACE = 3'd1,
        CMD_PUSH    = 3'd2,
        CMD_POP     = 3'd3,
        CMD_NEXT    = 3'd4
    } loop_cmd_e;

endpackage

// File: rtl/loop_stack_if.sv
// Command and status bundle between the control unit and the loop stack.
// Carries retired_iterations only when LOOP_STACK_PERF_EN is defined.
interface loop_stack_if;
    import loop_pkg::*;

    logic                             should_increment;
    logic                             should_create_new_loop;
    logic [BITS-1:0]                  new_loop_iteration_count;
    logic                             new_loop_is_inner_independent_loop;
    logic                             did_start_next_loop_iteration;
    logic                             did_finish_loop;
    logic                             done;
    logic [SUPERSCALAR_LOG_WIDTH-1:0] copy_count;
    logic [BITS-1:0]                  current_iteration;
    logic [DEPTH_W-1:0]               current_loop_depth;
    logic                             empty;
    logic                             full;
    logic                             overflow;
    logic                             underflow;
`ifdef LOOP_STACK_PERF_EN
    logic [PERF_W-1:0]                retired_iterations;
`endif

    modport master (
        output should_increment, should_create_new_loop, new_loop_iteration_count,
               new_loop_is_inner_independent_loop, did_start_next_loop_iteration,
               did_finish_loop,
        input
`ifdef LOOP_STACK_PERF_EN
               retired_iterations,
`endif
               done, copy_count, current_iteration, current_loop_depth,
               empty, full, overflow, underflow
    );

    modport slave (
        input  should_increment, should_create_new_loop, new_loop_iteration_count,
               new_loop_is_inner_independent_loop, did_start_next_loop_iteration,
               did_finish_loop,
        output
`ifdef LOOP_STACK_PERF_EN
               retired_iterations,
`endif
               done, copy_count, current_iteration, current_loop_depth,
               empty, full, overflow, underflow
    );

endinterface

// File: rtl/loop_stack_batch_calc.sv
// Combinational batch sizing for the top loop entry: remaining count,
// superscalar copy count (batch size minus one) and last-batch flag.
module loop_batch_calc
    import loop_pkg::*;
(
    input  loop_entry_t                      entry_i,
    input  logic                             valid_i,
    output logic [SUPERSCALAR_LOG_WIDTH-1:0] copy_count_o,
    output logic                             done_o,
    output logic [REM_W-1:0]                 remaining_o
);

    // Batch size is clipped to what is left; widened so count - iter never wraps.
    always_comb begin
        remaining_o  = '0;
        copy_count_o = '0;
        done_o       = 1'b0;
        if (valid_i) begin
            remaining_o = {1'b0, entry_i.count} - {1'b0, entry_i.iter};
            if (entry_i.indep) begin
                if (remaining_o >= REM_W'(SS_WIDTH)) begin
                    copy_count_o = SUPERSCALAR_LOG_WIDTH'(SS_WIDTH - 1);
                end else if (remaining_o == '0) begin
                    copy_count_o = '0;
                end else begin
                    copy_count_o = SUPERSCALAR_LOG_WIDTH'(remaining_o - REM_W'(1));
                end
            end else begin
                copy_count_o = '0;
            end
            done_o = (remaining_o <= (REM_W'(copy_count_o) + REM_W'(1)));
        end else begin
            remaining_o  = '0;
            copy_count_o = '0;
            done_o       = 1'b0;
        end
    end

endmodule

// File: rtl/loop_stack.sv
// Nested hardware loop stack: push/pop/replace of loop contexts and batched
// iteration advance. LOOP_STACK_PERF_EN adds a saturating retired-iteration count.
module loop_stack
    import loop_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    loop_stack_if.slave  bus
);

    localparam int IDX_W = LOOP_LOG_CNT;

    loop_entry_t                      entries_q [LOOP_CNT];
    loop_entry_t                      entries_d [LOOP_CNT];
    logic [DEPTH_W-1:0]               depth_q, depth_d;
    logic                             overflow_q, overflow_d;
    logic                             underflow_q, underflow_d;

    logic                             empty_s, full_s;
    logic [IDX_W-1:0]                 top_idx_s, push_idx_s;
    loop_entry_t                      top_entry_s, new_entry_s;
    logic [SUPERSCALAR_LOG_WIDTH-1:0] calc_cc_s;
    logic                             calc_done_s;
    logic [REM_W-1:0]                 calc_rem_s;
    logic [BITS-1:0]                  step_s;
    loop_cmd_e                        cmd_s;

    assign empty_s     = (depth_q == '0);
    assign full_s      = (depth_q == DEPTH_W'(LOOP_CNT));
    // At depth 0 the index wraps, but the entry is then marked invalid.
    assign top_idx_s   = depth_q[IDX_W-1:0] - IDX_W'(1);
    assign push_idx_s  = depth_q[IDX_W-1:0];
    assign top_entry_s = entries_q[top_idx_s];
    assign step_s      = BITS'(calc_cc_s) + BITS'(1);

    assign new_entry_s.count = bus.new_loop_iteration_count;
    assign new_entry_s.iter  = '0;
    assign new_entry_s.indep = bus.new_loop_is_inner_independent_loop;

    loop_batch_calc u_batch_calc (
        .entry_i      (top_entry_s),
        .valid_i      (!empty_s),
        .copy_count_o (calc_cc_s),
        .done_o       (calc_done_s),
        .remaining_o  (calc_rem_s)
    );

    // Resolve the per-cycle command by priority; a stall masks everything.
    always_comb begin
        cmd_s = CMD_NONE;
        if (!bus.should_increment) begin
            cmd_s = CMD_NONE;
        end else if (bus.should_create_new_loop && bus.did_finish_loop && !empty_s) begin
            cmd_s = CMD_REPLACE;
        end else if (bus.should_create_new_loop) begin
            cmd_s = CMD_PUSH;
        end else if (bus.did_finish_loop) begin
            cmd_s = CMD_POP;
        end else if (bus.did_start_next_loop_iteration && !empty_s && !calc_done_s
                     && (calc_rem_s != '0)) begin
            cmd_s = CMD_NEXT;
        end else begin
            cmd_s = CMD_NONE;
        end
    end

    // Next-state for the entry array, depth and sticky error flags.
    always_comb begin
        for (int i = 0; i < LOOP_CNT; i++) begin
            entries_d[i] = entries_q[i];
        end
        depth_d     = depth_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        case (cmd_s)
            CMD_REPLACE: begin
                entries_d[top_idx_s] = new_entry_s;
            end
            CMD_PUSH: begin
                if (full_s) begin
                    overflow_d = 1'b1;
                end else begin
                    entries_d[push_idx_s] = new_entry_s;
                    depth_d               = depth_q + DEPTH_W'(1);
                end
            end
            CMD_POP: begin
                if (empty_s) begin
                    underflow_d = 1'b1;
                end else begin
                    entries_d[top_idx_s] = '0;
                    depth_d              = depth_q - DEPTH_W'(1);
                end
            end
            CMD_NEXT: begin
                entries_d[top_idx_s].iter = top_entry_s.iter + step_s;
            end
            CMD_NONE: begin
                depth_d = depth_q;
            end
            default: begin
                depth_d = depth_q;
            end
        endcase
    end

    // Stack state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LOOP_CNT; i++) begin
                entries_q[i] <= '0;
            end
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < LOOP_CNT; i++) begin
                entries_q[i] <= entries_d[i];
            end
            depth_q     <= depth_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef LOOP_STACK_PERF_EN
    logic [PERF_W-1:0] retired_q, retired_d;
    logic [PERF_W:0]   retired_sum_s;
    logic [PERF_W-1:0] retired_add_s;

    // A finish retires the final batch of the popped loop.
    always_comb begin
        retired_add_s = '0;
        case (cmd_s)
            CMD_NEXT:    retired_add_s = PERF_W'(step_s);
            CMD_REPLACE: retired_add_s = PERF_W'(step_s);
            CMD_POP:     retired_add_s = empty_s ? '0 : PERF_W'(step_s);
            CMD_PUSH:    retired_add_s = '0;
            CMD_NONE:    retired_add_s = '0;
            default:     retired_add_s = '0;
        endcase
        retired_sum_s = {1'b0, retired_q} + {1'b0, retired_add_s};
        if (retired_sum_s[PERF_W]) begin
            retired_d = '1;
        end else begin
            retired_d = retired_sum_s[PERF_W-1:0];
        end
    end

    // Saturating retired-iteration counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign bus.retired_iterations = retired_q;
`endif

    assign bus.done               = calc_done_s;
    assign bus.copy_count         = calc_cc_s;
    assign bus.current_iteration  = empty_s ? '0 : top_entry_s.iter;
    assign bus.current_loop_depth = depth_q;
    assign bus.empty              = empty_s;
    assign bus.full               = full_s;
    assign bus.overflow           = overflow_q;
    assign bus.underflow          = underflow_q;

endmodule

// File: tb/tb_loop_stack.sv
// Directed scoreboard bench for loop_stack; checks retired_iterations when
// LOOP_STACK_PERF_EN is defined.
module tb_loop_stack;
    import loop_pkg::*;

    typedef struct {
        string                            tag;
        logic [DEPTH_W-1:0]               depth;
        logic [BITS-1:0]                  iter;
        logic [SUPERSCALAR_LOG_WIDTH-1:0] cc;
        logic                             done;
        logic                             ovf;
        logic                             unf;
    } exp_t;

    logic   clk;
    logic   reset;
    int     checks;
    int     errors;
    exp_t   sb [$];

    loop_stack_if bus ();

    loop_stack dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic idle_inputs();
        bus.should_increment                   = 1'b1;
        bus.should_create_new_loop             = 1'b0;
        bus.new_loop_iteration_count           = '0;
        bus.new_loop_is_inner_independent_loop = 1'b0;
        bus.did_start_next_loop_iteration      = 1'b0;
        bus.did_finish_loop                    = 1'b0;
    endtask

    task automatic compare_front();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".depth"}, 32'(bus.current_loop_depth), 32'(e.depth));
            chk({e.tag, ".iter"},  32'(bus.current_iteration),  32'(e.iter));
            chk({e.tag, ".cc"},    32'(bus.copy_count),         32'(e.cc));
            chk({e.tag, ".done"},  32'(bus.done),               32'(e.done));
            chk({e.tag, ".empty"}, 32'(bus.empty),              32'(e.depth == 3'd0));
            chk({e.tag, ".full"},  32'(bus.full),               32'(e.depth == 3'd4));
            chk({e.tag, ".ovf"},   32'(bus.overflow),           32'(e.ovf));
            chk({e.tag, ".unf"},   32'(bus.underflow),          32'(e.unf));
        end
    endtask

    task automatic step(input string tag, input logic inc, input logic cr,
                        input logic [BITS-1:0] n, input logic ind, input logic nx,
                        input logic fin, input int e_depth, input int e_iter,
                        input int e_cc, input logic e_done, input logic e_ovf,
                        input logic e_unf);
        exp_t e;
        bus.should_increment                   = inc;
        bus.should_create_new_loop             = cr;
        bus.new_loop_iteration_count           = n;
        bus.new_loop_is_inner_independent_loop = ind;
        bus.did_start_next_loop_iteration      = nx;
        bus.did_finish_loop                    = fin;
        e.tag   = tag;
        e.depth = DEPTH_W'(e_depth);
        e.iter  = BITS'(e_iter);
        e.cc    = SUPERSCALAR_LOG_WIDTH'(e_cc);
        e.done  = e_done;
        e.ovf   = e_ovf;
        e.unf   = e_unf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        idle_inputs();
        compare_front();
    endtask

    task automatic do_reset(input string tag);
        exp_t e;
        reset = 1'b1;
        e.tag = tag; e.depth = '0; e.iter = '0; e.cc = '0;
        e.done = 1'b0; e.ovf = 1'b0; e.unf = 1'b0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        reset = 1'b0;
        compare_front();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        idle_inputs();
        @(negedge clk);
        do_reset("reset");
`ifdef LOOP_STACK_PERF_EN
        chk("perf.reset", bus.retired_iterations, 32'd0);
`endif

        // Dependent N=3: one iteration per step.
        //     tag        inc  cr   n       ind  nx   fin  dep it cc done ovf unf
        step("dep.push",  1'b1,1'b1,15'd3, 1'b0,1'b0,1'b0, 1, 0, 0, 1'b0,1'b0,1'b0);
        step("dep.stall", 1'b0,1'b0,15'd0, 1'b0,1'b1,1'b0, 1, 0, 0, 1'b0,1'b0,1'b0);
        step("dep.nx1",   1'b1,1'b0,15'd0, 1'b0,1'b1,1'b0, 1, 1, 0, 1'b0,1'b0,1'b0);
        step("dep.nx2",   1'b1,1'b0,15'd0, 1'b0,1'b1,1'b0, 1, 2, 0, 1'b1,1'b0,1'b0);
        step("dep.nx3",   1'b1,1'b0,15'd0, 1'b0,1'b1,1'b0, 1, 2, 0, 1'b1,1'b0,1'b0);
        step("dep.fin",   1'b1,1'b0,15'd0, 1'b0,1'b0,1'b1, 0, 0, 0, 1'b0,1'b0,1'b0);
`ifdef LOOP_STACK_PERF_EN
        chk("perf.dep", bus.retired_iterations, 32'd3);
`endif

        // Independent N=10: batches of 4,4,2.
        do_reset("reset2");
        step("ind.push",  1'b1,1'b1,15'd10,1'b1,1'b0,1'b0, 1, 0, 3, 1'b0,1'b0,1'b0);
        step("ind.nx1",   1'b1,1'b0,15'd0, 1'b0,1'b1,1'b0, 1, 4, 3, 1'b0,1'b0,1'b0);
        step("ind.nx2",   1'b1,1'b0,15'd0, 1'b0,1'b1,1'b0, 1, 8, 1, 1'b1,1'b0,1'b0);
        step("ind.nx3",   1'b1,1'b0,15'd0, 1'b0,1'b1,1'b0, 1, 8, 1, 1'b1,1'b0,1'b0);
        step("ind.fin",   1'b1,1'b0,15'd0, 1'b0,1'b0,1'b1, 0, 0, 0, 1'b0,1'b0,1'b0);
`ifdef LOOP_STACK_PERF_EN
        chk("perf.ind", bus.retired_iterations, 32'd10);
`endif

        // Nesting with replace-top, and N=0.
        step("nest.outer",1'b1,1'b1,15'd20,1'b0,1'b0,1'b0, 1, 0, 0, 1'b0,1'b0,1'b0);
        step("nest.outnx",1'b1,1'b0,15'd0, 1'b0,1'b1,1'b0, 1, 1, 0, 1'b0,1'b0,1'b0);
        step("nest.inner",1'b1,1'b1,15'd2, 1'b0,1'b0,1'b0, 2, 0, 0, 1'b0,1'b0,1'b0);
        step("nest.innx", 1'b1,1'b0,15'd0, 1'b0,1'b1,1'b0, 2, 1, 0, 1'b1,1'b0,1'b0);
        step("nest.repl", 1'b1,1'b1,15'd2, 1'b0,1'b1,1'b1, 2, 0, 0, 1'b0,1'b0,1'b0);
        step("nest.pop",  1'b1,1'b0,15'd0, 1'b0,1'b0,1'b1, 1, 1, 0, 1'b0,1'b0,1'b0);
        step("nest.outnx2",1'b1,1'b0,15'd0,1'b0,1'b1,1'b0, 1, 2, 0, 1'b0,1'b0,1'b0);
        step("nest.fin",  1'b1,1'b0,15'd0, 1'b0,1'b0,1'b1, 0, 0, 0, 1'b0,1'b0,1'b0);
        step("zero.push", 1'b1,1'b1,15'd0, 1'b1,1'b0,1'b0, 1, 0, 0, 1'b1,1'b0,1'b0);
        step("zero.fin",  1'b1,1'b0,15'd0, 1'b0,1'b0,1'b1, 0, 0, 0, 1'b0,1'b0,1'b0);

        // Overflow, underflow, stall with both flags sticky.
        for (int i = 1; i <= 5; i++) begin
            step($sformatf("ovf.push%0d", i), 1'b1,1'b1,15'd5,1'b0,1'b0,1'b0,
                 (i > 4) ? 4 : i, 0, 0, 1'b0, (i > 4), 1'b0);
        end
        for (int i = 1; i <= 5; i++) begin
            step($sformatf("unf.pop%0d", i), 1'b1,1'b0,15'd0,1'b0,1'b0,1'b1,
                 (i > 4) ? 0 : 4 - i, 0, 0, 1'b0, 1'b1, (i > 4));
        end
        step("stall.cr",  1'b0,1'b1,15'd7, 1'b1,1'b0,1'b0, 0, 0, 0, 1'b0,1'b1,1'b1);

        // Mid-loop reset at depth 2 with flags still set.
        step("mid.outer", 1'b1,1'b1,15'd20,1'b0,1'b0,1'b0, 1, 0, 0, 1'b0,1'b1,1'b1);
        step("mid.inner", 1'b1,1'b1,15'd7, 1'b1,1'b0,1'b0, 2, 0, 3, 1'b0,1'b1,1'b1);
        step("mid.nx",    1'b1,1'b0,15'd0, 1'b0,1'b1,1'b0, 2, 4, 2, 1'b1,1'b1,1'b1);
        do_reset("mid.reset");
        step("post.idle", 1'b1,1'b0,15'd0, 1'b0,1'b1,1'b1, 0, 0, 0, 1'b0,1'b0,1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
